// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, response and ALU-side signals of alu_arbiter.
// The arbiter connects through the slave modport; the requesters/ALU side use master.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int CW   = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    REQ_VALID;
  logic [NREQ-1:0]    REQ_READY;
  logic [NREQ*DW-1:0] REQ_OPA;
  logic [NREQ*DW-1:0] REQ_OPB;
  logic [NREQ*CW-1:0] REQ_CMD;
  logic [NREQ-1:0]    REQ_MODE;
  logic [NREQ-1:0]    REQ_CIN;
  logic [2*NREQ-1:0]  REQ_INP_VALID;

  logic               RSP_VALID;
  logic               RSP_READY;
  logic [IDW-1:0]     RSP_ID;
  logic [2*DW-1:0]    RSP_RES;
  logic [5:0]         RSP_FLAGS;
  logic               BUSY;

  logic [DW-1:0]      ALU_OPA;
  logic [DW-1:0]      ALU_OPB;
  logic [CW-1:0]      ALU_CMD;
  logic               ALU_MODE;
  logic               ALU_CIN;
  logic               ALU_CE;
  logic [1:0]         ALU_INP_VALID;
  logic [2*DW-1:0]    ALU_RES;
  logic               ALU_COUT;
  logic               ALU_OFLOW;
  logic               ALU_ERR;
  logic               ALU_E;
  logic               ALU_G;
  logic               ALU_L;

  modport slave (
    input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID,
    output REQ_READY,
    output RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS, BUSY,
    input  RSP_READY,
    output ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_CE, ALU_INP_VALID,
    input  ALU_RES, ALU_COUT, ALU_OFLOW, ALU_ERR, ALU_E, ALU_G, ALU_L
  );

  modport master (
    output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID,
    input  REQ_READY,
    input  RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS, BUSY,
    output RSP_READY,
    input  ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_CE, ALU_INP_VALID,
    output ALU_RES, ALU_COUT, ALU_OFLOW, ALU_ERR, ALU_E, ALU_G, ALU_L
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among NREQ requesters,
// one operation in flight, responses tagged with the requester index.
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int LAT     = 1,
  parameter int LAT_MUL = 2
) (
  input  logic          CLK,
  input  logic          RST,
  alu_arbiter_if.slave  bus
);
  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] r_lat;
  logic [DW-1:0]   r_opa;
  logic [DW-1:0]   r_opb;
  logic [CW-1:0]   r_cmd;
  logic            r_mode;
  logic            r_cin;
  logic            r_ce;
  logic [1:0]      r_inp_valid;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [2*DW-1:0] r_rsp_res;
  logic [5:0]      r_rsp_flags;

  logic            w_any;
  logic [IDW-1:0]  w_win;
  int              w_idx;
  logic [NREQ-1:0] w_ready;
  logic [DW-1:0]   w_opa;
  logic [DW-1:0]   w_opb;
  logic [CW-1:0]   w_cmd;
  logic            w_mode;
  logic            w_cin;
  logic [1:0]      w_inp_valid;
  logic            w_is_mul;
  logic            w_capture;
  logic [IDW-1:0]  w_ptr_next;

  // Round-robin search: first valid requester at or above r_ptr, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = (int'(r_ptr) + i) % NREQ;
      w_win = (!w_any && bus.REQ_VALID[w_idx]) ? IDW'(w_idx) : w_win;
      w_any = w_any | bus.REQ_VALID[w_idx];
    end
  end

  // Winner's fields and latency class.
  always_comb begin
    w_opa       = bus.REQ_OPA[w_win*DW +: DW];
    w_opb       = bus.REQ_OPB[w_win*DW +: DW];
    w_cmd       = bus.REQ_CMD[w_win*CW +: CW];
    w_mode      = bus.REQ_MODE[w_win];
    w_cin       = bus.REQ_CIN[w_win];
    w_inp_valid = bus.REQ_INP_VALID[w_win*2 +: 2];
    w_is_mul    = w_mode && ((w_cmd == CW'(9)) || (w_cmd == CW'(10)));
    w_capture   = (r_state == S_WAIT) && (r_cnt <= CNTW'(1));
    w_ptr_next  = (r_id == IDW'(NREQ-1)) ? '0 : r_id + IDW'(1);
  end

  // Grant is gated by RST so it drops the instant reset asserts.
  always_comb begin
    w_ready = '0;
    if ((r_state == S_IDLE) && w_any && RST) begin
      w_ready[w_win] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE; else w_next = S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_capture) w_next = S_RESP; else w_next = S_WAIT;
      S_RESP:  if (bus.RSP_READY) w_next = S_IDLE; else w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Operand latch, countdown, response capture and pointer update.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_cmd       <= '0;
      r_mode      <= 1'b0;
      r_cin       <= 1'b0;
      r_ce        <= 1'b0;
      r_inp_valid <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_res   <= '0;
      r_rsp_flags <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id        <= w_win;
            r_opa       <= w_opa;
            r_opb       <= w_opb;
            r_cmd       <= w_cmd;
            r_mode      <= w_mode;
            r_cin       <= w_cin;
            r_inp_valid <= w_inp_valid;
            r_ce        <= 1'b1;
            r_lat       <= w_is_mul ? CNTW'(LAT_MUL) : CNTW'(LAT);
          end
        end
        S_ISSUE: r_cnt <= r_lat;
        S_WAIT: begin
          r_cnt <= (r_cnt != '0) ? r_cnt - CNTW'(1) : r_cnt;
          if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_res   <= bus.ALU_RES;
            r_rsp_flags <= {bus.ALU_COUT, bus.ALU_OFLOW, bus.ALU_ERR,
                            bus.ALU_E, bus.ALU_G, bus.ALU_L};
            r_ce        <= 1'b0;
            r_inp_valid <= 2'b00;
          end
        end
        S_RESP: begin
          if (bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_ptr_next;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.REQ_READY     = w_ready;
  assign bus.BUSY          = (r_state != S_IDLE);
  assign bus.RSP_VALID     = r_rsp_valid;
  assign bus.RSP_ID        = r_rsp_id;
  assign bus.RSP_RES       = r_rsp_res;
  assign bus.RSP_FLAGS     = r_rsp_flags;
  assign bus.ALU_OPA       = r_opa;
  assign bus.ALU_OPB       = r_opb;
  assign bus.ALU_CMD       = r_cmd;
  assign bus.ALU_MODE      = r_mode;
  assign bus.ALU_CIN       = r_cin;
  assign bus.ALU_CE        = r_ce;
  assign bus.ALU_INP_VALID = r_inp_valid;
endmodule
